imm_gen_pipe: RTL and testbench

//  Pipelined, XLEN-parametrised immediate generator for the miniRV decode stage.

---
 rtl/imm_gen_pipe.sv | 145 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator for the miniRV decode stage, feeding a DEPTH-entry valid/ready FIFO.
// Define IMMGEN_ERR_EN to add err_o and per-entry encoding-error tracking.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [2:0]             sext_op_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        imm_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef IMMGEN_ERR_EN
  ,
  output logic                   err_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_I     = 3'd0;
  localparam logic [2:0] OP_S     = 3'd1;
  localparam logic [2:0] OP_B     = 3'd2;
  localparam logic [2:0] OP_U     = 3'd3;
  localparam logic [2:0] OP_J     = 3'd4;
  localparam logic [2:0] OP_SLLI  = 3'd5;
  localparam logic [2:0] OP_SLTIU = 3'd6;

  // Size casts of signed fields sign-extend; casts of unsigned slices zero-extend.
  function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] inst, input logic [2:0] op);
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    logic [XLEN-1:0]    imm;
    i12 = inst[31:20];
    s12 = {inst[31:25], inst[11:7]};
    b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    u32 = {inst[31:12], 12'h000};
    j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    case (op)
      OP_I, OP_SLTIU: imm = XLEN'(i12);
      OP_S:           imm = XLEN'(s12);
      OP_B:           imm = XLEN'(b13);
      OP_U:           imm = XLEN'(u32);
      OP_J:           imm = XLEN'(j21);
      OP_SLLI: begin
        if (XLEN == 64) imm = XLEN'(inst[25:20]);
        else            imm = XLEN'(inst[24:20]);
      end
      default:        imm = XLEN'(inst[19:15]);
    endcase
    return imm;
  endfunction

  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [XLEN-1:0]  imm_mem_d [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  logic             unused_inst;

`ifdef IMMGEN_ERR_EN
  logic err_mem_q [DEPTH];
  logic err_mem_d [DEPTH];
  logic err_new;

  assign err_new = (inst_i[1:0] != 2'b11) ||
                   ((XLEN == 32) && (sext_op_i == OP_SLLI) && inst_i[25]);
  assign err_o   = err_mem_q[rd_ptr_q];
`endif

  // Opcode bits only matter to the optional error check.
  assign unused_inst = ^inst_i[6:0];

  // Handshake flags come from registered occupancy only, so no ready->ready path exists.
  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign imm_o   = imm_mem_q[rd_ptr_q];
  assign tag_o   = tag_mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    imm_mem_d = imm_mem_q;
    tag_mem_d = tag_mem_q;
`ifdef IMMGEN_ERR_EN
    err_mem_d = err_mem_q;
`endif
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      imm_mem_d[wr_ptr_q] = decode_imm(inst_i, sext_op_i);
      tag_mem_d[wr_ptr_q] = tag_i;
`ifdef IMMGEN_ERR_EN
      err_mem_d[wr_ptr_q] = err_new;
`endif
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Storage is cleared on reset too, so the head outputs read zero afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
`ifdef IMMGEN_ERR_EN
        err_mem_q[i] <= 1'b0;
`endif
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      imm_mem_q <= imm_mem_d;
      tag_mem_q <= tag_mem_d;
`ifdef IMMGEN_ERR_EN
      err_mem_q <= err_mem_d;
`endif
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance, directed vectors.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        va, ira, ova, ora, eea;
  logic [31:0] insta, imma;
  logic [2:0]  opa;
  logic [4:0]  taga, tgoa;
  logic [1:0]  cnta;
  logic [63:0] eia;
  logic        erra;

  logic        vb, irb, ovb, orb, eeb;
  logic [31:0] instb;
  logic [63:0] immb, eib;
  logic [2:0]  opb;
  logic [4:0]  tagb, tgob;
  logic [1:0]  cntb;
  logic        errb;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(va), .in_ready_o(ira),
    .inst_i(insta), .sext_op_i(opa), .tag_i(taga),
    .out_valid_o(ova), .out_ready_i(ora),
    .imm_o(imma), .tag_o(tgoa), .count_o(cnta)
`ifdef IMMGEN_ERR_EN
    , .err_o(erra)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(5)) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(vb), .in_ready_o(irb),
    .inst_i(instb), .sext_op_i(opb), .tag_i(tagb),
    .out_valid_o(ovb), .out_ready_i(orb),
    .imm_o(immb), .tag_o(tgob), .count_o(cntb)
`ifdef IMMGEN_ERR_EN
    , .err_o(errb)
`endif
  );

`ifndef IMMGEN_ERR_EN
  assign erra = 1'b0;
  assign errb = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [31:0] inst, input logic [2:0] op,
                       input logic [4:0] tag, input logic [63:0] ei, input logic ee);
    va = v; insta = inst; opa = op; taga = tag; eia = ei; eea = ee;
  endtask

  task automatic drv_b(input logic v, input logic [31:0] inst, input logic [2:0] op,
                       input logic [4:0] tag, input logic [63:0] ei);
    vb = v; instb = inst; opb = op; tagb = tag; eib = ei; eeb = 1'b0;
  endtask

  // Handshakes are judged mid-cycle; they take effect on the following rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ova && ora) begin
        if (qa.size() == 0) chk("a_unexpected_out", 64'(tgoa), 64'h1_0000_0000);
        else begin
          e = qa.pop_front();
          chk("a_imm", {32'h0, imma}, e.imm);
          chk("a_tag", 64'(tgoa), 64'(e.tag));
`ifdef IMMGEN_ERR_EN
          chk("a_err", 64'(erra), 64'(e.err));
`endif
        end
      end
      if (va && ira) qa.push_back('{eia, taga, eea});
      if (ovb && orb) begin
        if (qb.size() == 0) chk("b_unexpected_out", 64'(tgob), 64'h1_0000_0000);
        else begin
          e = qb.pop_front();
          chk("b_imm", immb, e.imm);
          chk("b_tag", 64'(tgob), 64'(e.tag));
`ifdef IMMGEN_ERR_EN
          chk("b_err", 64'(errb), 64'(e.err));
`endif
        end
      end
      if (vb && irb) qb.push_back('{eib, tagb, eeb});
    end
  end

  logic [31:0] ta_inst [9] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800000B7,
                               32'hFFDFF06F, 32'h00509093, 32'h8000B093, 32'h000FD073,
                               32'h0010B093};
  logic [2:0]  ta_op   [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
  logic [63:0] ta_exp  [9] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h80000000,
                               64'hFFFFFFFC, 64'h00000005, 64'hFFFFF800, 64'h0000001F,
                               64'h00000001};

  logic [31:0] tb_inst [5] = '{32'h800000B7, 32'h03F09093, 32'hFFF00093, 32'h02009093,
                               32'hFE000CE3};
  logic [2:0]  tb_op   [5] = '{3'd3, 3'd5, 3'd0, 3'd5, 3'd2};
  logic [63:0] tb_exp  [5] = '{64'hFFFFFFFF80000000, 64'h000000000000003F,
                               64'hFFFFFFFFFFFFFFFF, 64'h0000000000000020,
                               64'hFFFFFFFFFFFFFFF8};

  initial begin
    rst_n = 1'b0; ora = 1'b0; orb = 1'b0;
    drv_a(1'b0, 32'h0, 3'd0, 5'd0, 64'h0, 1'b0);
    drv_b(1'b0, 32'h0, 3'd0, 5'd0, 64'h0);
    repeat (2) tick;
    rst_n = 1'b1;
    chk("rst_count", 64'(cnta), 64'd0);
    chk("rst_out_valid", 64'(ova), 64'd0);
    chk("rst_in_ready", 64'(ira), 64'd1);
    chk("rst_imm", 64'(imma), 64'd0);
    chk("rst_tag", 64'(tgoa), 64'd0);
    chk("rst_b_imm", immb, 64'd0);

    // Back-to-back pushes through the 32-bit instance, consumer always ready.
    ora = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drv_a(1'b1, ta_inst[i], ta_op[i], 5'(i), ta_exp[i], 1'b0);
      tick;
      if (i == 0) begin
        chk("lat_out_valid", 64'(ova), 64'd1);
        chk("lat_imm", 64'(imma), 64'hFFFFFFFF);
      end
    end
    va = 1'b0;
    repeat (3) tick;
    chk("a_drained_count", 64'(cnta), 64'd0);

    // 64-bit instance: U-type upper replication and 6-bit shamt.
    orb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_b(1'b1, tb_inst[i], tb_op[i], 5'(20 + i), tb_exp[i]);
      tick;
    end
    vb = 1'b0;
    repeat (3) tick;
    chk("b_drained_count", 64'(cntb), 64'd0);

    // Fill with consumer stalled, third source held back.
    ora = 1'b0;
    drv_a(1'b1, 32'hFFF00093, 3'd0, 5'd1, 64'hFFFFFFFF, 1'b0);
    tick;
    drv_a(1'b1, 32'h0010B093, 3'd6, 5'd2, 64'h00000001, 1'b0);
    tick;
    chk("full_count", 64'(cnta), 64'd2);
    chk("full_in_ready", 64'(ira), 64'd0);
    drv_a(1'b1, 32'h000FD073, 3'd7, 5'd3, 64'h0000001F, 1'b0);
    repeat (2) tick;
    chk("held_count", 64'(cnta), 64'd2);
    ora = 1'b1;
    tick;
    chk("full_pop_only_count", 64'(cnta), 64'd1);
    tick;
    chk("push_pop_count", 64'(cnta), 64'd1);
    va = 1'b0;
    tick;
    chk("after_drain_count", 64'(cnta), 64'd0);

    // Reset while full; the input offered during reset must vanish.
    ora = 1'b0;
    drv_a(1'b1, 32'hFE112E23, 3'd1, 5'd4, 64'hFFFFFFFC, 1'b0);
    tick;
    drv_a(1'b1, 32'hFE000CE3, 3'd2, 5'd5, 64'hFFFFFFF8, 1'b0);
    tick;
    chk("pre_rst_count", 64'(cnta), 64'd2);
    rst_n = 1'b0;
    drv_a(1'b1, 32'h800000B7, 3'd3, 5'd6, 64'h80000000, 1'b0);
    tick;
    rst_n = 1'b1;
    va = 1'b0;
    chk("midrst_count", 64'(cnta), 64'd0);
    chk("midrst_out_valid", 64'(ova), 64'd0);
    chk("midrst_in_ready", 64'(ira), 64'd1);
    ora = 1'b1;
    repeat (3) tick;
    chk("midrst_still_empty", 64'(ova), 64'd0);

`ifdef IMMGEN_ERR_EN
    // Illegal RV32 shamt: flagged, but immediate still delivered.
    drv_a(1'b1, 32'h02009093, 3'd5, 5'd9, 64'h00000000, 1'b1);
    tick;
    va = 1'b0;
    chk("err_flag", 64'(erra), 64'd1);
    chk("err_imm", 64'(imma), 64'd0);
    drv_a(1'b1, 32'hFFF00090, 3'd0, 5'd10, 64'hFFFFFFFF, 1'b1);
    tick;
    va = 1'b0;
    repeat (2) tick;
`endif

    for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) tick;
    chk("queue_a_empty", 64'(qa.size()), 64'd0);
    chk("queue_b_empty", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
